// File: rtl/arbitro_pkg.sv
// arbitro_pkg: shared constants and helpers for the destination arbiter
package arbitro_pkg;
  localparam int MODE_GLOBAL = 0;
  localparam int MODE_PER_DEST = 1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction
  function automatic int dest_field(input logic [63:0] word, input int lsb, input int w);
    return int'((word >> lsb) & ((64'd1 << w) - 64'd1));
  endfunction
endpackage

// File: rtl/arbitro_n_if.sv
// arbitro_n_if: input FIFO read side, output FIFO bank side and counter readout
interface arbitro_n_if import arbitro_pkg::*; #(
  parameter int DATA_SIZE = 12,
  parameter int NUM_CH = 4,
  parameter int CNT_W = 5
);
  localparam int SEL_W = clog2(NUM_CH);
  logic [DATA_SIZE-1:0] data_in;
  logic valid;
  logic fifo_empty;
  logic [NUM_CH-1:0] almost_full;
  logic [SEL_W-1:0] cnt_sel;
  logic pop;
  logic [DATA_SIZE-1:0] data_out;
  logic [NUM_CH-1:0] push;
  logic [CNT_W-1:0] cnt_out;
  logic [CNT_W-1:0] drop_cnt;
  logic idle;
  modport master (
    input data_in, valid, fifo_empty, almost_full, cnt_sel,
    output pop, data_out, push, cnt_out, drop_cnt, idle
  );
  modport slave (
    output data_in, valid, fifo_empty, almost_full, cnt_sel,
    input pop, data_out, push, cnt_out, drop_cnt, idle
  );
endinterface

// File: rtl/skid2.sv
// skid2: two-entry in-order buffer; write at tail, read from head in the same edge
module skid2 #(
  parameter int DATA_SIZE = 12
) (
  input  logic clk,
  input  logic reset_L,
  input  logic wr_i,
  input  logic [DATA_SIZE-1:0] wdata_i,
  input  logic rd_i,
  output logic [1:0] occ_o,
  output logic [DATA_SIZE-1:0] head_o
);
  logic [1:0] occ_q, occ_d;
  logic [DATA_SIZE-1:0] e0_q, e0_d, e1_q, e1_d;
  // next occupancy; entry 0 is always the head, entry 1 the word behind it
  always_comb begin
    occ_d = occ_q + 2'(wr_i) - 2'(rd_i);
    e0_d = rd_i ? (occ_q[1] ? e1_q : wdata_i) : ((occ_q == 2'd0) ? wdata_i : e0_q);
    e1_d = (occ_q == (rd_i ? 2'd2 : 2'd1)) ? wdata_i : e1_q;
  end
  // state update; reset flushes anything buffered
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      occ_q <= '0;
      e0_q <= '0;
      e1_q <= '0;
    end else begin
      occ_q <= occ_d;
      e0_q <= e0_d;
      e1_q <= e1_d;
    end
  end
  assign occ_o = occ_q;
  assign head_o = e0_q;
endmodule

// File: rtl/arbitro_n.sv
// arbitro_n: routes input FIFO words to NUM_CH output FIFOs by destination field
module arbitro_n import arbitro_pkg::*; #(
  parameter int DATA_SIZE = 12,
  parameter int NUM_CH = 4,
  parameter int DEST_LSB = 8,
  parameter int DEST_W = 2,
  parameter int MODE = MODE_PER_DEST,
  parameter int CNT_W = 5
) (
  input logic clk,
  input logic reset_L,
  arbitro_n_if.master bus
);
  localparam int SEL_W = clog2(NUM_CH);
  localparam int DN = 1 << DEST_W;
  typedef logic [DN-1:0] dn_t;
  typedef logic [NUM_CH-1:0] ch_t;
  logic [1:0] occ;
  logic [DATA_SIZE-1:0] head;
  logic [DEST_W-1:0] dest;
  dn_t af_ext;
  logic out_rng, blocked, drop, deliver, drain;
  ch_t push_q, push_d;
  logic [DATA_SIZE-1:0] data_q;
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_out_q, drop_q;
  skid2 #(.DATA_SIZE(DATA_SIZE)) u_skid (
    .clk(clk),
    .reset_L(reset_L),
    .wr_i(bus.valid),
    .wdata_i(bus.data_in),
    .rd_i(drain),
    .occ_o(occ),
    .head_o(head)
  );
  // head disposition: drop out-of-range, hold when blocked, otherwise deliver
  always_comb begin
    dest = DEST_W'(dest_field(64'(head), DEST_LSB, DEST_W));
    af_ext = dn_t'(bus.almost_full);
    out_rng = int'(dest) >= NUM_CH;
    blocked = (MODE == MODE_GLOBAL) ? |bus.almost_full : af_ext[dest];
    drop = (occ != 2'd0) & out_rng;
    deliver = (occ != 2'd0) & ~out_rng & ~blocked;
    drain = drop | deliver;
    push_d = deliver ? ch_t'(dn_t'(1) << dest) : '0;
  end
  // pop only when the word it fetches is sure to find a free slot
  assign bus.pop = reset_L & ~bus.fifo_empty & ((3'(occ) + 3'(bus.valid)) <= (3'(drain) + 3'd1));
  // output registers and wrapping delivery/drop counters
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      push_q <= '0;
      data_q <= '0;
      cnt_q <= '{default: '0};
      cnt_out_q <= '0;
      drop_q <= '0;
    end else begin
      push_q <= push_d;
      if (deliver) begin
        data_q <= head;
        cnt_q[SEL_W'(dest)] <= cnt_q[SEL_W'(dest)] + CNT_W'(1);
      end
      if (drop) drop_q <= drop_q + CNT_W'(1);
      cnt_out_q <= (int'(bus.cnt_sel) < NUM_CH) ? cnt_q[bus.cnt_sel] : '0;
    end
  end
  assign bus.push = push_q;
  assign bus.data_out = data_q;
  assign bus.cnt_out = cnt_out_q;
  assign bus.drop_cnt = drop_q;
  assign bus.idle = (occ == 2'd0) & ~bus.valid & bus.fifo_empty;
endmodule

// File: tb/tb_arbitro_n.sv
// tb_arbitro_n: global-stall and per-destination instances against an in-order scoreboard
module tb_arbitro_n;
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;
  arbitro_n_if #(.DATA_SIZE(12), .NUM_CH(4), .CNT_W(5)) bg ();
  arbitro_n_if #(.DATA_SIZE(12), .NUM_CH(4), .CNT_W(5)) bp ();
  arbitro_n #(.DATA_SIZE(12), .NUM_CH(4), .DEST_LSB(8), .DEST_W(3), .MODE(0), .CNT_W(5)) u_g (
    .clk(clk), .reset_L(reset_L), .bus(bg));
  arbitro_n #(.DATA_SIZE(12), .NUM_CH(4), .DEST_LSB(8), .DEST_W(3), .MODE(1), .CNT_W(5)) u_p (
    .clk(clk), .reset_L(reset_L), .bus(bp));
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [11:0] src [2][$];
  logic [11:0] exp_q [2][$];
  int cnt_m [2][4];
  int drops_m [2];
  int obs [2][4];
  int npush [2];
  int first_pop [2];
  int first_push [2];
  int last_push [2];
  logic pend [2];
  logic [11:0] pend_w [2];
  logic [3:0] af = '0;
  logic [3:0] af_prev = '0;
  logic [1:0] sel = '0;
  task automatic chk(input string tag, input int i, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, i, o, e);
    end
  endtask
  function automatic logic [11:0] mkword(input int d);
    logic [11:0] w;
    w = 12'($urandom);
    w[10:8] = 3'(d);
    return w;
  endfunction
  task automatic feed(input int d);
    logic [11:0] w;
    w = mkword(d);
    src[0].push_back(w);
    src[1].push_back(w);
  endtask
  task automatic observe(input int i, input logic [3:0] pu, input logic [11:0] dout,
                         input logic v, input logic [11:0] din, input logic pp);
    logic [11:0] w;
    int d;
    if (pu != 4'd0) begin
      npush[i]++;
      for (int c = 0; c < 4; c++) if (pu[c]) obs[i][c]++;
      if (first_push[i] < 0) first_push[i] = cyc;
      last_push[i] = cyc;
      if (exp_q[i].size() == 0) chk("spurious_push", i, 32'(pu), 32'd0);
      else begin
        w = exp_q[i].pop_front();
        d = int'(w[10:8]);
        chk("push_onehot", i, 32'(pu), 32'(4'b0001 << d));
        chk("data_out", i, 32'(dout), 32'(w));
        chk("push_allowed", i, 32'((i == 0) ? (af_prev == 4'd0) : !af_prev[d]), 32'd1);
        cnt_m[i][d]++;
      end
    end
    if (!reset_L) begin
      exp_q[i].delete();
      for (int c = 0; c < 4; c++) cnt_m[i][c] = 0;
      drops_m[i] = 0;
    end else if (v) begin
      if (din[10:8] < 3'd4) exp_q[i].push_back(din);
      else drops_m[i]++;
    end
    pend[i] = pp && (src[i].size() > 0);
    if (pend[i]) pend_w[i] = src[i].pop_front();
    if (pp && first_pop[i] < 0) first_pop[i] = cyc;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bg.valid = pend[0];
    bg.data_in = pend_w[0];
    bg.fifo_empty = (src[0].size() == 0);
    bp.valid = pend[1];
    bp.data_in = pend_w[1];
    bp.fifo_empty = (src[1].size() == 0);
    bg.almost_full = af;
    bp.almost_full = af;
    bg.cnt_sel = sel;
    bp.cnt_sel = sel;
    @(negedge clk);
    observe(0, bg.push, bg.data_out, bg.valid, bg.data_in, bg.pop);
    observe(1, bp.push, bp.data_out, bp.valid, bp.data_in, bp.pop);
    af_prev = af;
  endtask
  task automatic run(input int n);
    repeat (n) tick();
  endtask
  function automatic bit quiet();
    return src[0].size() == 0 && src[1].size() == 0 && !pend[0] && !pend[1] &&
           exp_q[0].size() == 0 && exp_q[1].size() == 0 && bg.idle && bp.idle;
  endfunction
  task automatic drain(input int lim);
    int k = 0;
    while (!quiet() && k < lim) begin
      tick();
      k++;
    end
    chk("drain_done", 0, 32'(quiet()), 32'd1);
  endtask
  task automatic chk_counts();
    for (int c = 0; c < 4; c++) begin
      sel = 2'(c);
      run(2);
      chk($sformatf("cnt_out_ch%0d", c), 0, 32'(bg.cnt_out), 32'(cnt_m[0][c] & 31));
      chk($sformatf("cnt_out_ch%0d", c), 1, 32'(bp.cnt_out), 32'(cnt_m[1][c] & 31));
    end
    chk("drop_cnt", 0, 32'(bg.drop_cnt), 32'(drops_m[0] & 31));
    chk("drop_cnt", 1, 32'(bp.drop_cnt), 32'(drops_m[1] & 31));
  endtask
  task automatic mark();
    for (int i = 0; i < 2; i++) begin
      first_pop[i] = -1;
      first_push[i] = -1;
      last_push[i] = -1;
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n0, n1, o0, o1;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0;
      pend_w[i] = '0;
      npush[i] = 0;
      drops_m[i] = 0;
      for (int c = 0; c < 4; c++) begin
        cnt_m[i][c] = 0;
        obs[i][c] = 0;
      end
    end
    mark();
    bg.valid = 1'b0; bg.data_in = '0; bg.fifo_empty = 1'b1; bg.almost_full = '0; bg.cnt_sel = '0;
    bp.valid = 1'b0; bp.data_in = '0; bp.fifo_empty = 1'b1; bp.almost_full = '0; bp.cnt_sel = '0;
    run(3);
    chk("rst_push", 0, 32'(bg.push), 0);
    chk("rst_push", 1, 32'(bp.push), 0);
    chk("rst_data", 0, 32'(bg.data_out), 0);
    chk("rst_data", 1, 32'(bp.data_out), 0);
    chk("rst_cnt_out", 0, 32'(bg.cnt_out), 0);
    chk("rst_cnt_out", 1, 32'(bp.cnt_out), 0);
    chk("rst_drop", 0, 32'(bg.drop_cnt), 0);
    chk("rst_drop", 1, 32'(bp.drop_cnt), 0);
    chk("rst_pop", 0, 32'(bg.pop), 0);
    chk("rst_idle", 0, 32'(bg.idle), 1);
    chk("rst_idle", 1, 32'(bp.idle), 1);
    reset_L = 1'b1;
    // eight words round-robin, no backpressure: latency 3, one push per cycle
    mark();
    for (int k = 0; k < 8; k++) feed(k % 4);
    drain(100);
    for (int i = 0; i < 2; i++) begin
      chk("latency", i, 32'(first_push[i] - first_pop[i]), 32'd3);
      chk("back_to_back", i, 32'(last_push[i] - first_push[i]), 32'd7);
    end
    chk_counts();
    // channel 1 almost full: dest-1 head held in both modes, then in-order release
    af = 4'b0010;
    n0 = npush[0];
    n1 = npush[1];
    feed(1);
    feed(2);
    run(10);
    chk("held_af1", 0, 32'(npush[0] - n0), 0);
    chk("held_af1", 1, 32'(npush[1] - n1), 0);
    af = 4'b0000;
    drain(100);
    // channel 3 almost full, dest-0 words: global mode stalls with two buffered
    af = 4'b1000;
    n0 = npush[0];
    n1 = npush[1];
    for (int k = 0; k < 5; k++) feed(0);
    run(12);
    chk("global_stall", 0, 32'(npush[0] - n0), 0);
    chk("global_pop_off", 0, 32'(bg.pop), 0);
    chk("global_src_left", 0, 32'(src[0].size()), 32'd3);
    chk("perdest_flow", 1, 32'(npush[1] - n1), 32'd5);
    af = 4'b0000;
    drain(100);
    // out-of-range destination between two dest-0 words
    o0 = obs[0][0];
    o1 = obs[1][0];
    feed(0);
    feed(5);
    feed(0);
    drain(100);
    chk("drop_pushes", 0, 32'(obs[0][0] - o0), 32'd2);
    chk("drop_pushes", 1, 32'(obs[1][0] - o1), 32'd2);
    chk("drop_one", 0, 32'(bg.drop_cnt), 32'd1);
    chk("drop_one", 1, 32'(bp.drop_cnt), 32'd1);
    // randomized traffic with random backpressure
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 1) == 1 && src[0].size() < 6)
        feed(($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 7));
      if ($urandom_range(0, 4) == 0) af = 4'($urandom & $urandom);
      tick();
    end
    af = 4'b0000;
    drain(200);
    chk_counts();
    // reset with both buffers full
    af = 4'b1111;
    for (int k = 0; k < 2; k++) feed(1);
    run(8);
    chk("pre_rst_busy", 0, 32'(bg.idle), 0);
    chk("pre_rst_busy", 1, 32'(bp.idle), 0);
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
    af = 4'b0000;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("post_rst_push", i, 32'(i == 0 ? bg.push : bp.push), 0);
      chk("post_rst_idle", i, 32'(i == 0 ? bg.idle : bp.idle), 1);
      chk("post_rst_cnt", i, 32'(i == 0 ? bg.cnt_out : bp.cnt_out), 0);
      chk("post_rst_drop", i, 32'(i == 0 ? bg.drop_cnt : bp.drop_cnt), 0);
    end
    // 35 words to channel 2 wrap the 5-bit counter to 3
    for (int k = 0; k < 35; k++) feed(2);
    drain(200);
    sel = 2'd2;
    run(2);
    chk("wrap_ch2", 0, 32'(bg.cnt_out), 32'd3);
    chk("wrap_ch2", 1, 32'(bp.cnt_out), 32'd3);
    chk_counts();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
